// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls and instruction-memory data in,
// program counter and IF/ID pipeline register out.
// master: the side that drives controls and memory data (pipeline/testbench).
// slave:  the fetch unit itself.
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] instruction;
  logic [31:0] readAddress;
  logic [31:0] ifidInstruction;
  logic [31:0] ifidPC;
  logic        ifidValid;
  logic        halted;
  logic [31:0] fetchCount;
  logic        fetchFault;

  modport master (
    output stall, flush, branchTaken, branchTarget, instruction,
    input  readAddress, ifidInstruction, ifidPC, ifidValid,
           halted, fetchCount, fetchFault
  );

  modport slave (
    input  stall, flush, branchTaken, branchTarget, instruction,
    output readAddress, ifidInstruction, ifidPC, ifidValid,
           halted, fetchCount, fetchFault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory data into IF/ID,
// handles stall/flush/redirect and halts on a fetched all-zero word.
//
// Optional feature macro: FETCH_FAULT_EN
//   defined   : misaligned redirect targets halt the unit and set a sticky
//               fetchFault; the fault blocks any later redirect out of HALT.
//   undefined : redirect target bits [1:0] are forced to zero, fetchFault = 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | one settle cycle so memory evaluates RESET_PC; no capture
// RUN   | normal fetch (redirect > flush > stall > zero word > capture)
// HALT  | fetch stopped; only a (legal) redirect resumes
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic   clock,
  input  logic   resetN,
  fetch_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;

  logic        target_bad;
  logic [31:0] target_pc;

`ifdef FETCH_FAULT_EN
  assign target_bad = (bus.branchTarget[1:0] != 2'b00);
  assign target_pc  = bus.branchTarget;
`else
  // Low target bits are dropped, so the redirect is always legal.
  logic unused_target_lsb;
  assign unused_target_lsb = ^bus.branchTarget[1:0];
  assign target_bad = 1'b0;
  assign target_pc  = {bus.branchTarget[31:2], 2'b00};
`endif

  // Next-state and next-register computation; every register holds by default.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    fault_d      = fault_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (bus.branchTaken) begin
          // A redirect squashes the word fetched from the old path.
          ifid_instr_d = NOP_WORD;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b0;
          if (target_bad) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = target_pc;
          end
        end else if (bus.flush) begin
          ifid_instr_d = NOP_WORD;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (bus.instruction == 32'h0) begin
          // Memory reads zero past the end of the program.
          state_d      = HALT;
          ifid_instr_d = NOP_WORD;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b0;
        end else begin
          ifid_instr_d = bus.instruction;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_STEP;
          count_d      = count_q + 32'd1;
        end
      end

      HALT: begin
        // Zeros may have been fetched speculatively past a branch, so a
        // redirect restarts fetch unless a fault has been latched.
        if (bus.branchTaken && !fault_q) begin
          if (target_bad) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = target_pc;
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    halted_d = (state_d == HALT);
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= 32'h0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      count_q      <= 32'h0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.readAddress     = pc_q;
  assign bus.ifidInstruction = ifid_instr_q;
  assign bus.ifidPC          = ifid_pc_q;
  assign bus.ifidValid       = ifid_valid_q;
  assign bus.halted          = halted_q;
  assign bus.fetchCount      = count_q;
  assign bus.fetchFault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction-memory
// model (32 words at 0x00..0x7C, one word at 0xFFFF_FFFC, zero elsewhere).
module tb_fetch_unit;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:31];
  logic [31:0] top_word;

  fetch_if bus ();

  fetch_unit dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always_comb begin
    bus.instruction = 32'h0;
    if (bus.readAddress < 32'h80)
      bus.instruction = mem[bus.readAddress[6:2]];
    else if (bus.readAddress == 32'hFFFF_FFFC)
      bus.instruction = top_word;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branchTaken = 1'b0;
    bus.branchTarget = 32'h0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    top_word = 32'h0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    clear_inputs();
    resetN = 1'b0;
    step();
    step();
    checks++; if (bus.readAddress !== 32'h0) begin errors++; $display("FAIL reset_ra actual=%h required=%h", bus.readAddress, 32'h0); end
    checks++; if (bus.ifidInstruction !== 32'h13) begin errors++; $display("FAIL reset_instr actual=%h required=%h", bus.ifidInstruction, 32'h13); end
    checks++; if (bus.ifidPC !== 32'h0) begin errors++; $display("FAIL reset_pc actual=%h required=%h", bus.ifidPC, 32'h0); end
    checks++; if (bus.ifidValid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", bus.ifidValid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted actual=%b required=0", bus.halted); end
    checks++; if (bus.fetchCount !== 32'h0) begin errors++; $display("FAIL reset_count actual=%0d required=0", bus.fetchCount); end
    checks++; if (bus.fetchFault !== 1'b0) begin errors++; $display("FAIL reset_fault actual=%b required=0", bus.fetchFault); end
  endtask

  task automatic test_boot_run();
    resetN = 1'b1;
    step();
    checks++; if (bus.ifidValid !== 1'b0 || bus.readAddress !== 32'h0) begin errors++; $display("FAIL boot_hold actual=%b/%h required=0/00000000", bus.ifidValid, bus.readAddress); end
    step();
    checks++; if (bus.ifidValid !== 1'b1 || bus.ifidPC !== 32'h0 || bus.ifidInstruction !== 32'h0050_0093) begin errors++; $display("FAIL first_fetch actual=%b/%h/%h required=1/00000000/00500093", bus.ifidValid, bus.ifidPC, bus.ifidInstruction); end
    checks++; if (bus.readAddress !== 32'h4 || bus.fetchCount !== 32'd1) begin errors++; $display("FAIL first_ra actual=%h/%0d required=00000004/1", bus.readAddress, bus.fetchCount); end
    step();
    checks++; if (bus.ifidValid !== 1'b1 || bus.ifidPC !== 32'h4 || bus.ifidInstruction !== 32'h00A0_0113) begin errors++; $display("FAIL second_fetch actual=%b/%h/%h required=1/00000004/00a00113", bus.ifidValid, bus.ifidPC, bus.ifidInstruction); end
    step();
    checks++; if (bus.halted !== 1'b1 || bus.readAddress !== 32'h8 || bus.fetchCount !== 32'd2) begin errors++; $display("FAIL eop_halt actual=%b/%h/%0d required=1/00000008/2", bus.halted, bus.readAddress, bus.fetchCount); end
    checks++; if (bus.ifidValid !== 1'b0 || bus.ifidInstruction !== 32'h13) begin errors++; $display("FAIL eop_bubble actual=%b/%h required=0/00000013", bus.ifidValid, bus.ifidInstruction); end
    step();
    checks++; if (bus.halted !== 1'b1 || bus.readAddress !== 32'h8) begin errors++; $display("FAIL halt_stays actual=%b/%h required=1/00000008", bus.halted, bus.readAddress); end
  endtask

  task automatic test_stall();
    fill_mem();
    do_reset();
    step(); step(); step();
    checks++; if (bus.readAddress !== 32'h8 || bus.ifidPC !== 32'h4 || bus.fetchCount !== 32'd2) begin errors++; $display("FAIL pre_stall actual=%h/%h/%0d required=00000008/00000004/2", bus.readAddress, bus.ifidPC, bus.fetchCount); end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.readAddress !== 32'h8 || bus.ifidPC !== 32'h4 || bus.fetchCount !== 32'd2) begin errors++; $display("FAIL stall_hold_%0d actual=%h/%h/%0d required=00000008/00000004/2", i, bus.readAddress, bus.ifidPC, bus.fetchCount); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.ifidPC !== 32'h8 || bus.readAddress !== 32'hC || bus.fetchCount !== 32'd3) begin errors++; $display("FAIL stall_resume actual=%h/%h/%0d required=00000008/0000000c/3", bus.ifidPC, bus.readAddress, bus.fetchCount); end
  endtask

  task automatic test_branch_stall();
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h40;
    bus.stall = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.readAddress !== 32'h40) begin errors++; $display("FAIL br_ra actual=%h required=00000040", bus.readAddress); end
    checks++; if (bus.ifidValid !== 1'b0 || bus.ifidInstruction !== 32'h13 || bus.ifidPC !== 32'hC) begin errors++; $display("FAIL br_bubble actual=%b/%h/%h required=0/00000013/0000000c", bus.ifidValid, bus.ifidInstruction, bus.ifidPC); end
    step();
    checks++; if (bus.ifidValid !== 1'b1 || bus.ifidPC !== 32'h40 || bus.ifidInstruction !== 32'h1000_0010) begin errors++; $display("FAIL br_target actual=%b/%h/%h required=1/00000040/10000010", bus.ifidValid, bus.ifidPC, bus.ifidInstruction); end
    checks++; if (bus.readAddress !== 32'h44 || bus.fetchCount !== 32'd4) begin errors++; $display("FAIL br_next actual=%h/%0d required=00000044/4", bus.readAddress, bus.fetchCount); end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.ifidValid !== 1'b0 || bus.readAddress !== 32'h44 || bus.fetchCount !== 32'd4) begin errors++; $display("FAIL flush actual=%b/%h/%0d required=0/00000044/4", bus.ifidValid, bus.readAddress, bus.fetchCount); end
    step();
    checks++; if (bus.ifidValid !== 1'b1 || bus.ifidPC !== 32'h44 || bus.fetchCount !== 32'd5) begin errors++; $display("FAIL flush_resume actual=%b/%h/%0d required=1/00000044/5", bus.ifidValid, bus.ifidPC, bus.fetchCount); end
  endtask

  task automatic test_back_to_back();
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h20;
    step();
    bus.branchTarget = 32'h60;
    step();
    clear_inputs();
    checks++; if (bus.readAddress !== 32'h60 || bus.ifidValid !== 1'b0 || bus.ifidPC !== 32'h20) begin errors++; $display("FAIL b2b_last actual=%h/%b/%h required=00000060/0/00000020", bus.readAddress, bus.ifidValid, bus.ifidPC); end
    step();
    checks++; if (bus.ifidPC !== 32'h60 || bus.ifidValid !== 1'b1 || bus.fetchCount !== 32'd6) begin errors++; $display("FAIL b2b_target actual=%h/%b/%0d required=00000060/1/6", bus.ifidPC, bus.ifidValid, bus.fetchCount); end
  endtask

  task automatic test_halt_redirect();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0093;
    mem[4] = 32'h0011_0113;
    mem[5] = 32'h0021_0113;
    do_reset();
    step(); step(); step();
    checks++; if (bus.halted !== 1'b1 || bus.readAddress !== 32'h4) begin errors++; $display("FAIL hr_halt actual=%b/%h required=1/00000004", bus.halted, bus.readAddress); end
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    clear_inputs();
    checks++; if (bus.halted !== 1'b1 || bus.readAddress !== 32'h4 || bus.ifidValid !== 1'b0) begin errors++; $display("FAIL hr_ignore actual=%b/%h/%b required=1/00000004/0", bus.halted, bus.readAddress, bus.ifidValid); end
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h10;
    step();
    clear_inputs();
    checks++; if (bus.halted !== 1'b0 || bus.readAddress !== 32'h10) begin errors++; $display("FAIL hr_exit actual=%b/%h required=0/00000010", bus.halted, bus.readAddress); end
    step();
    checks++; if (bus.ifidValid !== 1'b1 || bus.ifidPC !== 32'h10 || bus.ifidInstruction !== 32'h0011_0113 || bus.fetchCount !== 32'd2) begin errors++; $display("FAIL hr_fetch actual=%b/%h/%h/%0d required=1/00000010/00110113/2", bus.ifidValid, bus.ifidPC, bus.ifidInstruction, bus.fetchCount); end
    resetN = 1'b0;
    step();
    checks++; if (bus.readAddress !== 32'h0 || bus.ifidValid !== 1'b0 || bus.ifidPC !== 32'h0 || bus.ifidInstruction !== 32'h13 || bus.fetchCount !== 32'h0 || bus.halted !== 1'b0 || bus.fetchFault !== 1'b0) begin
      errors++; $display("FAIL midrun_reset actual=%h/%b/%h/%h/%0d/%b/%b required=00000000/0/00000000/00000013/0/0/0", bus.readAddress, bus.ifidValid, bus.ifidPC, bus.ifidInstruction, bus.fetchCount, bus.halted, bus.fetchFault);
    end
    resetN = 1'b1;
  endtask

  task automatic test_wrap();
    fill_mem();
    top_word = 32'h00A0_0093;
    do_reset();
    step(); step();
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks++; if (bus.readAddress !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ra actual=%h required=fffffffc", bus.readAddress); end
    step();
    checks++; if (bus.readAddress !== 32'h0 || bus.ifidPC !== 32'hFFFF_FFFC || bus.ifidInstruction !== 32'h00A0_0093) begin errors++; $display("FAIL wrap_next actual=%h/%h/%h required=00000000/fffffffc/00a00093", bus.readAddress, bus.ifidPC, bus.ifidInstruction); end
  endtask

  task automatic test_misaligned();
    fill_mem();
    do_reset();
    step(); step();
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h22;
    step();
    clear_inputs();
`ifdef FETCH_FAULT_EN
    checks++; if (bus.halted !== 1'b1 || bus.fetchFault !== 1'b1 || bus.readAddress !== 32'h4) begin errors++; $display("FAIL mis_fault actual=%b/%b/%h required=1/1/00000004", bus.halted, bus.fetchFault, bus.readAddress); end
    bus.branchTaken = 1'b1;
    bus.branchTarget = 32'h40;
    step();
    clear_inputs();
    checks++; if (bus.halted !== 1'b1 || bus.readAddress !== 32'h4 || bus.fetchFault !== 1'b1) begin errors++; $display("FAIL mis_sticky actual=%b/%h/%b required=1/00000004/1", bus.halted, bus.readAddress, bus.fetchFault); end
`else
    checks++; if (bus.readAddress !== 32'h20 || bus.halted !== 1'b0 || bus.fetchFault !== 1'b0) begin errors++; $display("FAIL mis_align actual=%h/%b/%b required=00000020/0/0", bus.readAddress, bus.halted, bus.fetchFault); end
    step();
    checks++; if (bus.ifidPC !== 32'h20 || bus.ifidValid !== 1'b1 || bus.readAddress !== 32'h24) begin errors++; $display("FAIL mis_continue actual=%h/%b/%h required=00000020/1/00000024", bus.ifidPC, bus.ifidValid, bus.readAddress); end
`endif
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_stall();
    test_branch_stall();
    test_flush();
    test_back_to_back();
    test_halt_redirect();
    test_wrap();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
